bram_byte_rmw_ctrl: RTL and testbench

//   Request-side controller for a single-port, read-first, word-write-only BRAM.

---
 rtl/bram_byte_rmw_ctrl.sv | 110 +++++++++++
 tb/tb_bram_byte_rmw_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bram_byte_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bram_byte_rmw_ctrl
// Description : Request-side controller for a read-first, word-write BRAM;
//               emulates byte enables with read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_byte_rmw_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DI_WIDTH   = 8,
    parameter int NB         = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [NB-1:0]          req_be,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [NB*DI_WIDTH-1:0] req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [NB*DI_WIDTH-1:0] rsp_data,
    output logic                   busy,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [NB*DI_WIDTH-1:0] ram_di,
    input  logic [NB*DI_WIDTH-1:0] ram_do
);

    localparam int W = NB * DI_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CAP  = 3'd2,
        S_WR   = 3'd3,
        S_WCAP = 3'd4,
        S_RSP  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [NB-1:0]         be_q;
    logic                  we_q;
    logic                  full_q;
    logic [W-1:0]          di_q;
    logic [W-1:0]          old_q;
    logic [W-1:0]          merged_w;

    // di_q holds the request write data until CAP overwrites it with the merge
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign merged_w[i*DI_WIDTH +: DI_WIDTH] = be_q[i] ? di_q[i*DI_WIDTH +: DI_WIDTH]
                                                          : ram_do[i*DI_WIDTH +: DI_WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            full_q  <= 1'b0;
            di_q    <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req_valid) begin
                addr_q <= req_addr;
                be_q   <= req_be;
                // a write with no strobes behaves exactly like a read
                we_q   <= req_we && (|req_be);
                full_q <= req_we && (&req_be);
                di_q   <= req_wdata;
            end
            if (state_q == S_CAP) begin
                old_q <= ram_do;
                di_q  <= merged_w;
            end
            if (state_q == S_WCAP) begin
                old_q <= ram_do;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (req_valid) state_d = (req_we && (&req_be)) ? S_WR : S_RD;
            S_RD:   state_d = S_CAP;
            S_CAP:  state_d = we_q ? S_WR : S_RSP;
            S_WR:   state_d = full_q ? S_WCAP : S_RSP;
            S_WCAP: state_d = S_RSP;
            S_RSP:  if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_data  = old_q;
    assign ram_en    = (state_q == S_RD) || (state_q == S_WR);
    assign ram_we    = (state_q == S_WR);
    assign ram_addr  = addr_q;
    assign ram_di    = di_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_byte_rmw_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_byte_rmw_ctrl
// Description : Directed self-checking bench with a read-first RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_byte_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_be = 2'b00;
    logic [8:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [15:0] rsp_data;
    logic        busy;
    logic        ram_en;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [15:0] ram_di;
    logic [15:0] ram_do = '0;

    logic [15:0] mem [0:511];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          we_pulses = 0;

    bram_byte_rmw_ctrl #(.ADDR_WIDTH(9), .DI_WIDTH(8), .NB(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            ram_do <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_di;
        end
        if (ram_we) we_pulses <= we_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request; cycle numbers are relative to the accept edge (T).
    task automatic xact(input logic we, input logic [1:0] be, input logic [8:0] addr,
                        input logic [15:0] wd, output int we_cyc, output int we_cnt,
                        output logic [15:0] di, output int rsp_cyc, output logic [15:0] rd);
        we_cyc = 0; we_cnt = 0; di = '0; rsp_cyc = 0; rd = '0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            if (ram_we) begin
                if (we_cnt == 0) begin we_cyc = k; di = ram_di; end
                we_cnt++;
            end
            if (rsp_valid) begin
                rsp_cyc = k; rd = rsp_data;
                break;
            end
            @(negedge clk);
        end
        if (rsp_cyc == 0) check("rsp_timeout", 32'd0, 32'd1);
        @(posedge clk);
    endtask

    int          wc, wn, rc;
    logic [15:0] di, rd;
    int          base, seen;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[5] = 16'h1234; mem[7] = 16'h1234; mem[3] = 16'hBEEF; mem[9] = 16'h5555;

        // 1: reset values, then reassert mid-idle
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ram_di", 32'(ram_di), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // 2: full write
        xact(1'b1, 2'b11, 9'd5, 16'hA5C3, wc, wn, di, rc, rd);
        check("fw_we_cyc", 32'(wc), 32'd1);
        check("fw_we_cnt", 32'(wn), 32'd1);
        check("fw_di", 32'(di), 32'hA5C3);
        check("fw_rsp_cyc", 32'(rc), 32'd3);
        check("fw_rsp_data", 32'(rd), 32'h1234);
        check("fw_mem5", 32'(mem[5]), 32'hA5C3);

        // 3: partial writes and read-back
        xact(1'b1, 2'b01, 9'd7, 16'hFF77, wc, wn, di, rc, rd);
        check("pw0_we_cyc", 32'(wc), 32'd3);
        check("pw0_we_cnt", 32'(wn), 32'd1);
        check("pw0_di", 32'(di), 32'h1277);
        check("pw0_rsp_cyc", 32'(rc), 32'd4);
        check("pw0_rsp_data", 32'(rd), 32'h1234);
        xact(1'b0, 2'b11, 9'd7, 16'h0000, wc, wn, di, rc, rd);
        check("rd7_we_cnt", 32'(wn), 32'd0);
        check("rd7_rsp_cyc", 32'(rc), 32'd3);
        check("rd7_rsp_data", 32'(rd), 32'h1277);
        xact(1'b1, 2'b10, 9'd7, 16'hAB00, wc, wn, di, rc, rd);
        check("pw1_di", 32'(di), 32'hAB77);
        check("pw1_rsp_data", 32'(rd), 32'h1277);
        check("pw1_mem7", 32'(mem[7]), 32'hAB77);

        // 4: zero-strobe write acts as a read
        xact(1'b1, 2'b00, 9'd3, 16'h0000, wc, wn, di, rc, rd);
        check("be0_we_cnt", 32'(wn), 32'd0);
        check("be0_rsp_cyc", 32'(rc), 32'd3);
        check("be0_rsp_data", 32'(rd), 32'hBEEF);
        check("be0_mem3", 32'(mem[3]), 32'hBEEF);

        // 5: response backpressure with a second request held waiting
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_be = 2'b11; req_addr = 9'd5;
        @(posedge clk);
        @(negedge clk);
        req_addr = 9'd7;
        seen = 0;
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check("bp_rsp_seen", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'hA5C3);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_addr", 32'(ram_addr), 32'd5);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(req_ready), 32'd1);
        check("bp_addr_hold", 32'(ram_addr), 32'd5);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_accept_addr", 32'(ram_addr), 32'd7);
        check("bp_accept_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        check("bp2_rsp_data", 32'(rsp_data), 32'hAB77);
        @(negedge clk);

        // 6: reset during CAP of a partial write
        base = we_pulses;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_be = 2'b01; req_addr = 9'd9; req_wdata = 16'h00AA;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("ir_busy", 32'(busy), 32'd0);
        check("ir_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ir_ram_we", 32'(ram_we), 32'd0);
        check("ir_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("ir_rsp_valid_after", 32'(rsp_valid), 32'd0);
        check("ir_we_pulses", 32'(we_pulses - base), 32'd0);
        check("ir_mem9", 32'(mem[9]), 32'h5555);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
